// File: rtl/lc4_uart_pkg.sv
// lc4_uart_pkg
// Shared constants for the LC4 memory-mapped UART transmitter:
//   - serial FSM state encoding
//   - default status / data register addresses
//   - bit positions inside the status word
package lc4_uart_pkg;

  // Serial engine states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Default memory-mapped register addresses.
  localparam logic [15:0] DEF_STATUS_ADDR = 16'hFE04;
  localparam logic [15:0] DEF_DATA_ADDR   = 16'hFE06;

  // Status word layout.
  localparam int STAT_READY_BIT = 15;
  localparam int STAT_OVF_BIT   = 14;
  localparam int STAT_IDLE_BIT  = 0;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous FIFO of DEPTH x 8 bits with first-word-fall-through read data.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, push_data write request and byte
//   pop             read request (ignored when empty)
//   pop_data        byte at the head of the FIFO
//   full, empty     occupancy flags
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lc4_uart_tx.sv
// lc4_uart_tx
// Memory-mapped 8N1 serial transmitter for the LC4 processor.
// Stores to DATA_ADDR queue a byte; stores to STATUS_ADDR clear the sticky
// overflow flag; loads from STATUS_ADDR return {ready, overflow, ..., idle}.
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   gwe             global write enable, gates bus writes only
//   i_we, i_addr    processor data-memory write enable and address
//   i_wdata         store data (bits [7:0] used at DATA_ADDR)
//   o_rdata         combinational read data
//   o_tx            registered serial line, idle high
module lc4_uart_tx
  import lc4_uart_pkg::*;
#(
  parameter int                   WORD_SIZE   = 16,
  parameter int                   CLK_DIV     = 104,
  parameter int                   FIFO_DEPTH  = 4,
  parameter logic [WORD_SIZE-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [WORD_SIZE-1:0] DATA_ADDR   = DEF_DATA_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gwe,
  input  logic                 i_we,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] o_rdata,
  output logic                 o_tx
);

  localparam int            CW     = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          tx_nxt;
  logic          ovf;

  logic          wr_data, wr_status;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          tc;

  logic          unused_wdata_hi;
  assign unused_wdata_hi = ^i_wdata[WORD_SIZE-1:8];

  assign wr_data   = gwe && i_we && (i_addr == DATA_ADDR);
  assign wr_status = gwe && i_we && (i_addr == STATUS_ADDR);
  assign tc        = (baud_cnt == '0);

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_data),
    .push_data(i_wdata[7:0]),
    .pop      (fifo_pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Serial engine next-state logic. The line value is derived from the next
  // state so o_tx can be a plain register that changes on the same edge as
  // the state.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift_reg;
    fifo_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_nxt    = fifo_dout;
          state_nxt    = ST_START;
          baud_cnt_nxt = DIV_M1;
        end
      end
      ST_START: begin
        if (tc) begin
          state_nxt    = ST_DATA;
          bit_idx_nxt  = 3'd0;
          baud_cnt_nxt = DIV_M1;
        end else begin
          baud_cnt_nxt = baud_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          shift_nxt    = {1'b0, shift_reg[7:1]};
          baud_cnt_nxt = DIV_M1;
          if (bit_idx == 3'd7) begin
            state_nxt   = ST_STOP;
            bit_idx_nxt = 3'd0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            shift_nxt    = fifo_dout;
            state_nxt    = ST_START;
            baud_cnt_nxt = DIV_M1;
          end else begin
            state_nxt    = ST_IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        baud_cnt_nxt = '0;
        bit_idx_nxt  = 3'd0;
      end
    endcase

    case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      o_tx      <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
      o_tx      <= tx_nxt;
    end
  end

  // Overflow is sticky; a drop and a clear on the same edge leaves it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (wr_data && fifo_full && !fifo_pop) begin
      ovf <= 1'b1;
    end else if (wr_status) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_addr == STATUS_ADDR) begin
      o_rdata[STAT_READY_BIT] = !fifo_full;
      o_rdata[STAT_OVF_BIT]   = ovf;
      o_rdata[STAT_IDLE_BIT]  = (state == ST_IDLE) && fifo_empty;
    end
  end

endmodule

// File: tb/tb_lc4_uart_tx.sv
// tb_lc4_uart_tx
// Self-checking bench for lc4_uart_tx with CLK_DIV=4 and FIFO_DEPTH=4.
// Bytes expected on the line are queued when written; a serial monitor
// decodes each frame from o_tx and compares it with the queue head.
module tb_lc4_uart_tx;

  localparam int          DIV         = 4;
  localparam logic [15:0] STATUS_ADDR = 16'hFE04;
  localparam logic [15:0] DATA_ADDR   = 16'hFE06;

  logic        clk;
  logic        rst;
  logic        gwe;
  logic        i_we;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_tx;

  int total_checks;
  int bad_checks;

  logic [7:0] exp_q[$];
  int         start_cycles[$];
  int         frames_done;
  int         cycle_no;
  bit         mon_active;
  int         mon_off;
  logic [7:0] mon_byte;

  lc4_uart_tx #(
    .WORD_SIZE  (16),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (4),
    .STATUS_ADDR(STATUS_ADDR),
    .DATA_ADDR  (DATA_ADDR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .gwe    (gwe),
    .i_we   (i_we),
    .i_addr (i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_tx   (o_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One bus write lasting exactly one clock edge.
  task automatic applyStimulus(input logic g, input logic [15:0] addr,
                               input logic [15:0] data);
    gwe     = g;
    i_we    = 1'b1;
    i_addr  = addr;
    i_wdata = data;
    @(posedge clk);
    #1;
    i_we    = 1'b0;
    gwe     = 1'b0;
    i_addr  = 16'h0000;
    i_wdata = 16'h0000;
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr,
                           input logic [15:0] expected);
    i_addr = addr;
    #1;
    checkOutput(tag, o_rdata, expected);
    i_addr = 16'h0000;
  endtask

  task automatic waitFrames(input string tag, input int target, input int budget);
    int left;
    left = budget;
    while (frames_done < target && left > 0) begin
      @(posedge clk);
      left--;
    end
    #1;
    checkOutput(tag, frames_done, target);
  endtask

  // Serial monitor: sample mid-bit on the falling edge, bit i of a frame
  // occupies offsets 4i..4i+3 from the first low sample.
  always @(negedge clk) begin
    cycle_no++;
    if (!rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (o_tx == 1'b0) begin
        mon_active = 1'b1;
        mon_off    = 0;
        start_cycles.push_back(cycle_no);
      end
    end else begin
      mon_off++;
    end
    if (mon_active && (mon_off % DIV) == DIV / 2) begin
      int idx;
      idx = mon_off / DIV;
      if (idx == 0) begin
        checkOutput("start_bit", o_tx, 1'b0);
      end else if (idx <= 8) begin
        mon_byte[idx-1] = o_tx;
      end else begin
        checkOutput("stop_bit", o_tx, 1'b1);
        checkOutput("sb_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) checkOutput("frame_byte", mon_byte, exp_q.pop_front());
        frames_done++;
      end
    end
    if (mon_active && mon_off == 10 * DIV - 1) mon_active = 1'b0;
  end

  initial begin
    int base;
    total_checks = 0;
    bad_checks   = 0;
    frames_done  = 0;
    cycle_no     = 0;
    mon_active   = 1'b0;
    mon_off      = 0;
    mon_byte     = 8'h00;
    rst     = 1'b0;
    gwe     = 1'b0;
    i_we    = 1'b0;
    i_addr  = 16'h0000;
    i_wdata = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_tx", o_tx, 1'b1);
    readCheck("reset_status", STATUS_ADDR, 16'h8001);

    // Single byte 0x55 with junk in the upper half.
    $display("[TB] single byte");
    exp_q.push_back(8'h55);
    applyStimulus(1'b1, DATA_ADDR, 16'hAB55);
    checkOutput("lat_push_edge", o_tx, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("lat_start", o_tx, 1'b0);
    waitFrames("frames_single", 1, 80);
    repeat (3) @(posedge clk);
    #1;
    readCheck("status_after_single", STATUS_ADDR, 16'h8001);

    // Three back-to-back frames.
    $display("[TB] back to back");
    start_cycles.delete();
    for (int b = 1; b <= 3; b++) begin
      exp_q.push_back(8'(b));
      applyStimulus(1'b1, DATA_ADDR, 16'(b));
    end
    waitFrames("frames_b2b", 4, 200);
    checkOutput("b2b_starts", start_cycles.size(), 3);
    if (start_cycles.size() == 3) begin
      checkOutput("b2b_gap1", start_cycles[1] - start_cycles[0], 10 * DIV);
      checkOutput("b2b_gap2", start_cycles[2] - start_cycles[1], 10 * DIV);
    end
    repeat (3) @(posedge clk);
    #1;
    readCheck("status_after_b2b", STATUS_ADDR, 16'h8001);

    // Overflow: six writes, the sixth is dropped.
    $display("[TB] overflow");
    for (int b = 0; b < 6; b++) begin
      if (b < 5) exp_q.push_back(8'h10 + 8'(b));
      applyStimulus(1'b1, DATA_ADDR, 16'h0010 + 16'(b));
    end
    readCheck("status_ovf", STATUS_ADDR, 16'h4000);
    applyStimulus(1'b1, STATUS_ADDR, 16'h0000);
    readCheck("status_ovf_clr", STATUS_ADDR, 16'h0000);
    waitFrames("frames_ovf", 9, 400);
    repeat (3) @(posedge clk);
    #1;
    readCheck("status_after_ovf", STATUS_ADDR, 16'h8001);

    // Writes that must not push.
    $display("[TB] gated writes");
    applyStimulus(1'b0, DATA_ADDR, 16'h00A5);
    applyStimulus(1'b1, 16'hFE08, 16'h005A);
    readCheck("rdata_other_addr", 16'hFE08, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      repeat (5) @(posedge clk);
      #1;
      checkOutput("gated_tx_idle", o_tx, 1'b1);
    end
    checkOutput("gated_no_frame", frames_done, 9);
    readCheck("status_after_gated", STATUS_ADDR, 16'h8001);

    // Push into a full FIFO on the same edge that STOP pops the head.
    $display("[TB] full push with pop");
    for (int b = 0; b < 5; b++) begin
      exp_q.push_back(8'hC0 + 8'(b));
      applyStimulus(1'b1, DATA_ADDR, 16'h00C0 + 16'(b));
    end
    repeat (36) @(posedge clk);
    #1;
    readCheck("status_full", STATUS_ADDR, 16'h0000);
    exp_q.push_back(8'hC5);
    applyStimulus(1'b1, DATA_ADDR, 16'h00C5);
    readCheck("status_full_pop_push", STATUS_ADDR, 16'h0000);
    waitFrames("frames_full", 15, 400);
    repeat (3) @(posedge clk);
    #1;
    readCheck("status_after_full", STATUS_ADDR, 16'h8001);

    // Reset mid-frame aborts the line and discards queued bytes.
    $display("[TB] reset mid frame");
    applyStimulus(1'b1, DATA_ADDR, 16'h0000);
    applyStimulus(1'b1, DATA_ADDR, 16'h0033);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("pre_reset_tx", o_tx, 1'b0);
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_async_tx", o_tx, 1'b1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    base = frames_done;
    readCheck("status_after_reset", STATUS_ADDR, 16'h8001);
    repeat (60) @(posedge clk);
    #1;
    checkOutput("reset_tx_idle", o_tx, 1'b1);
    checkOutput("reset_no_frame", frames_done, base);
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/lc4_uart_tx.md
Name: lc4_uart_tx

Overview:
- Memory-mapped RS-232 transmitter for the LC4 system: the processor's outbound serial path, complementing the inbound RS232_rx path.
- Decodes processor data-memory writes to a data register and pushes bytes into a small FIFO.
- A baud-rate engine serialises the bytes as 8N1 frames on the RS232_tx pin.
- Exposes a status word through the same memory-mapped read path.

Parameters:
- WORD_SIZE, 16, width of the processor address and data buses.
- CLK_DIV, 104, clock cycles per serial bit; legal range 2 or more.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2 or more.
- STATUS_ADDR, 16'hFE04, status register address.
- DATA_ADDR, 16'hFE06, transmit data register address.

Ports:
- clk  input  1  system clock (proc_clk).
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- gwe  input  1  global write enable; bus writes are honoured only when gwe=1.
- i_we  input  1  processor data-memory write enable.
- i_addr  input  WORD_SIZE  processor data-memory address.
- i_wdata  input  WORD_SIZE  processor store data; only bits [7:0] are used at DATA_ADDR.
- o_rdata  output  WORD_SIZE  read data; combinational from i_addr and registered state.
- o_tx  output  1  serial line; idle high; registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_tx=1, FSM=IDLE, FIFO empty, overflow flag=0, baud counter=0, bit index=0.
  - Reset asserted mid-frame aborts the frame immediately and discards FIFO contents.
- Push:
  - Condition: gwe & i_we & i_addr==DATA_ADDR, sampled at the clock edge.
  - Accepted if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and the overflow flag is set (sticky).
- Overflow clear: gwe & i_we & i_addr==STATUS_ADDR clears the overflow flag. A set and a clear on the same edge resolves to set.
- Status word (o_rdata when i_addr==STATUS_ADDR):
  - bit15 = ready (FIFO not full).
  - bit14 = overflow.
  - bit0 = idle (FSM==IDLE and FIFO empty).
  - All other bits 0.
- o_rdata for any other address: 0. Reads have no side effects.
- FSM states: IDLE, START, DATA, STOP. Each non-IDLE state lasts exactly CLK_DIV cycles, timed by a counter that runs from CLK_DIV-1 down to 0.
  - IDLE: o_tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START on that edge, so o_tx=0 from the next cycle.
  - START: o_tx=0. On terminal count, go to DATA with bit index 0.
  - DATA: o_tx = shift[0], LSB first. On terminal count, shift right; after bit index 7, go to STOP.
  - STOP: o_tx=1. On terminal count, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle cycle); otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO while in IDLE produces o_tx=0 on the cycle after the push edge plus one. The push edge registers the byte; the next edge pops it and drives the start bit.
- Frame length: exactly 10*CLK_DIV cycles.
- gwe gates only bus writes. The serial engine runs on every clk regardless of gwe.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full = pointer MSBs differ and the low bits are equal.
  - empty = pointers equal.
- Upper bits i_wdata[15:8] are ignored on push.

Decomposition:
- Package lc4_uart_pkg holds:
  - the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3);
  - default STATUS_ADDR and DATA_ADDR constants;
  - status bit positions (READY=15, OVF=14, IDLE=0).
- One sub-module, uart_tx_fifo: a synchronous FIFO, FIFO_DEPTH x 8, with push/pop/full/empty and the same clk/rst. Pop-when-empty is ignored.
- Baud counter, FSM and address decode stay in lc4_uart_tx.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset, then read STATUS_ADDR -> o_rdata=16'h8001 and o_tx=1. Hold rst=0 for 3 cycles mid-frame -> o_tx=1 immediately, and status reads 16'h8001 after release.
- Write 16'hAB55 to DATA_ADDR with gwe=1 -> o_tx low 2 cycles after the write edge; the line carries 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop), each bit held 4 cycles; 40-cycle frame; status returns to 16'h8001.
- Write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap between STOP and the next START; bytes appear in order.
- Write 6 bytes back-to-back while byte 1 is in START -> 5 accepted (1 popped plus 4 queued), the 6th dropped; status reads 16'h4000 (overflow set, not ready). Then write to STATUS_ADDR -> 16'h0000 until the FIFO drains.
- Write DATA_ADDR with gwe=0 -> no push and o_tx stays 1. Write with gwe=1 to address 16'hFE08 -> no push, and o_rdata=0 at that address.
- Fill the FIFO to full, then push in the same cycle that STOP pops the head -> push accepted, overflow stays 0, and all bytes are transmitted in order.
